// File: rtl/dm_arbiter.sv
// Data-memory arbiter: single-cycle CPU (priority) vs. host burst port, with a starvation limit.
// Optional perf counters are compiled in when DM_ARB_PERF_EN is defined.
module dm_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int BURST_W      = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_stall,
    output logic [DATA_W-1:0]  cpu_rdata,
    input  logic               host_cmd_valid,
    output logic               host_cmd_ready,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [BURST_W-1:0] host_len,
    input  logic               host_wvalid,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic               host_wready,
    output logic               host_rvalid,
    output logic [DATA_W-1:0]  host_rdata,
    output logic               host_done,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
`ifdef DM_ARB_PERF_EN
    ,
    output logic [15:0]        perf_stall_cyc,
    output logic [15:0]        perf_host_beats
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             r_state, w_next;
    logic               r_we;
    logic [BURST_W-1:0] r_len, r_beat_cnt;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [SW-1:0]      r_starve_cnt;
    logic               r_rvalid, r_done;
    logic [DATA_W-1:0]  r_rdata;

    logic w_host_want, w_host_gnt, w_starved, w_last, w_accept;

    assign w_starved   = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign w_host_want = (r_state == BURST) && (!r_we || host_wvalid);
    assign w_host_gnt  = w_host_want && (!cpu_req || w_starved);
    assign w_last      = (r_beat_cnt == r_len);
    assign w_accept    = host_cmd_valid && host_cmd_ready;

    assign host_cmd_ready = (r_state == IDLE);
    assign cpu_gnt        = cpu_req && !w_host_gnt;
    assign cpu_stall      = cpu_req && !cpu_gnt;
    assign cpu_rdata      = mem_rdata;
    assign host_wready    = w_host_gnt && r_we;
    assign host_rvalid    = r_rvalid;
    assign host_rdata     = r_rdata;
    assign host_done      = r_done;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (w_host_gnt) begin
            mem_we    = r_we;
            mem_addr  = r_cur_addr;
            mem_wdata = host_wdata;
        end else if (cpu_gnt) begin
            mem_we = cpu_we;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BURST;
            BURST:   if (w_host_gnt && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_cur_addr   <= '0;
            r_starve_cnt <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= w_host_gnt && !r_we;
            r_done   <= w_host_gnt && w_last;
            if (w_accept) begin
                r_we       <= host_we;
                r_len      <= host_len;
                r_cur_addr <= host_addr;
                r_beat_cnt <= '0;
            end
            if (w_host_gnt) begin
                r_cur_addr <= r_cur_addr + ADDR_W'(1);
                r_beat_cnt <= r_beat_cnt + BURST_W'(1);
                if (!r_we) r_rdata <= mem_rdata;
            end
            // Only a cycle the host actually wanted and lost counts toward starvation.
            if (w_host_gnt)
                r_starve_cnt <= '0;
            else if (w_host_want && cpu_req && !w_starved)
                r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cyc  <= '0;
            perf_host_beats <= '0;
        end else begin
            if (cpu_stall && perf_stall_cyc != 16'hFFFF)
                perf_stall_cyc <= perf_stall_cyc + 16'd1;
            if (w_host_gnt && perf_host_beats != 16'hFFFF)
                perf_host_beats <= perf_host_beats + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 16x8 memory model (combinational read, clocked write).
module tb_dm_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 0, cpu_we = 0;
    logic [3:0] cpu_addr = 0;
    logic [7:0] cpu_wdata = 0;
    logic       cpu_gnt, cpu_stall;
    logic [7:0] cpu_rdata;
    logic       host_cmd_valid = 0, host_we = 0, host_wvalid = 0;
    logic       host_cmd_ready, host_wready, host_rvalid, host_done;
    logic [3:0] host_addr = 0, host_len = 0;
    logic [7:0] host_wdata = 0, host_rdata;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
`ifdef DM_ARB_PERF_EN
    logic [15:0] perf_stall_cyc, perf_host_beats;
`endif

    logic [7:0] mem [16];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    dm_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
        .host_wvalid(host_wvalid), .host_wdata(host_wdata), .host_wready(host_wready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_done(host_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DM_ARB_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_host_beats(perf_host_beats)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs change there, checks follow #1 later.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] wd [4];
        logic [3:0] wa [4];
        wd = '{8'h11, 8'h22, 8'h33, 8'h44};
        wa = '{4'd14, 4'd15, 4'd0, 4'd1};
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset state
        #2;
        chk("rst_cmd_ready", host_cmd_ready, 1);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_done", host_done, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        nxt(); reset = 1'b1;

        // 1: CPU write then read at addr 3
        nxt(); cpu_req = 1; cpu_we = 1; cpu_addr = 4'd3; cpu_wdata = 8'h5A; #1;
        chk("t1_gnt_w", cpu_gnt, 1);
        chk("t1_memwe", mem_we, 1);
        nxt(); cpu_we = 0; #1;
        chk("t1_gnt_r", cpu_gnt, 1);
        chk("t1_stall", cpu_stall, 0);
        chk("t1_rdata", cpu_rdata, 8'h5A);
        cpu_req = 0;

        // 2: host write burst addr 14 len 3, wraps past 15
        nxt(); host_cmd_valid = 1; host_we = 1; host_addr = 4'd14; host_len = 4'd3; #1;
        chk("t2_cmd_ready", host_cmd_ready, 1);
        for (int b = 0; b < 4; b++) begin
            nxt(); host_cmd_valid = 0; host_wvalid = 1; host_wdata = wd[b]; #1;
            chk("t2_wready", host_wready, 1);
            chk("t2_addr", mem_addr, wa[b]);
            chk("t2_done_early", host_done, 0);
            chk("t2_busy", host_cmd_ready, 0);
        end
        nxt(); host_wvalid = 0; #1;
        chk("t2_done", host_done, 1);
        chk("t2_m14", mem[14], 8'h11);
        chk("t2_m15", mem[15], 8'h22);
        chk("t2_m0", mem[0], 8'h33);
        chk("t2_m1", mem[1], 8'h44);

        // 3: host read burst addr 0 len 1
        nxt(); host_cmd_valid = 1; host_we = 0; host_addr = 4'd0; host_len = 4'd1; #1;
        chk("t3_done_clr", host_done, 0);
        nxt(); host_cmd_valid = 0; #1;
        chk("t3_addr0", mem_addr, 0);
        chk("t3_rvalid0", host_rvalid, 0);
        nxt(); #1;
        chk("t3_rvalid1", host_rvalid, 1);
        chk("t3_rdata1", host_rdata, 8'h33);
        chk("t3_done1", host_done, 0);
        nxt(); #1;
        chk("t3_rvalid2", host_rvalid, 1);
        chk("t3_rdata2", host_rdata, 8'h44);
        chk("t3_done2", host_done, 1);
        nxt(); #1;
        chk("t3_rvalid_end", host_rvalid, 0);

        // 4: contention, host read addr 14 len 0 forced after 4 lost cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3;
        host_cmd_valid = 1; host_we = 0; host_addr = 4'd14; host_len = 4'd0; #1;
        chk("t4_cmd_gnt", cpu_gnt, 1);
        for (int c = 0; c < 4; c++) begin
            nxt(); host_cmd_valid = 0; #1;
            chk("t4_cpu_gnt", cpu_gnt, 1);
            chk("t4_no_stall", cpu_stall, 0);
        end
        nxt(); #1;
        chk("t4_forced_gnt", cpu_gnt, 0);
        chk("t4_forced_stall", cpu_stall, 1);
        chk("t4_forced_addr", mem_addr, 14);
        nxt(); #1;
        chk("t4_resume", cpu_gnt, 1);
        chk("t4_rvalid", host_rvalid, 1);
        chk("t4_rdata", host_rdata, 8'h11);
        chk("t4_done", host_done, 1);

        // 5: write burst with no data yields to CPU, starvation does not build
        nxt(); host_cmd_valid = 1; host_we = 1; host_addr = 4'd5; host_len = 4'd0; host_wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            nxt(); host_cmd_valid = 0; #1;
            chk("t5_cpu_gnt", cpu_gnt, 1);
            chk("t5_wready", host_wready, 0);
            chk("t5_starve", dut.r_starve_cnt, 0);
        end
        nxt(); host_wvalid = 1; host_wdata = 8'h77; #1;
        chk("t5_cpu_prio", cpu_gnt, 1);
        chk("t5_no_beat", host_wready, 0);
        nxt(); cpu_req = 0; #1;
        chk("t5_beat", host_wready, 1);
        chk("t5_beat_addr", mem_addr, 5);
        nxt(); host_wvalid = 0; #1;
        chk("t5_done", host_done, 1);
        chk("t5_m5", mem[5], 8'h77);

        // 6: reset mid-burst after 2 of 4 beats
        nxt(); host_cmd_valid = 1; host_we = 1; host_addr = 4'd8; host_len = 4'd3;
        nxt(); host_cmd_valid = 0; host_wvalid = 1; host_wdata = 8'hA1;
        nxt(); host_wdata = 8'hA2;
        nxt(); host_wdata = 8'hA3; reset = 1'b0; #1;
        chk("t6_ready_rst", host_cmd_ready, 1);
        chk("t6_wready_rst", host_wready, 0);
        chk("t6_rvalid_rst", host_rvalid, 0);
        chk("t6_done_rst", host_done, 0);
        nxt(); reset = 1'b1; host_wvalid = 0; #1;
        chk("t6_ready_rel", host_cmd_ready, 1);
        nxt(); #1;
        chk("t6_no_done", host_done, 0);
        chk("t6_m9", mem[9], 8'hA2);
        chk("t6_m10", mem[10], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end
endmodule
